// File: rtl/relu_pipe.sv
// relu_pipe -- two-stage, multi-lane ReLU with optional upper clamp and a
// per-frame count of negative elements.
//
// Each beat carries LANES signed fixed-point elements of DATA_W bits.
// Lane i sits at in_data[i*DATA_W +: DATA_W], and out_data uses the same
// packing. For each lane:
//   - a negative element becomes 0. When RELU_LEAKY_EN is defined it
//     becomes x >>> LEAK_SHIFT instead.
//   - a non-negative element passes through unchanged. When the beat's
//     clamp_en is set, it is limited to CLAMP_MAX.
//
// Stage 1 captures the beat, its last flag, its clamp flag and the
// per-lane sign bits. Stage 2 holds the activated result and drives out_*.
// Both stages share a single enable (out_ready | ~out_valid). A stalled
// output therefore freezes the whole pipe, and in_ready simply mirrors
// that enable.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   in_valid/in_ready  input handshake
//   in_data, in_last   packed input lanes and the end-of-frame marker
//   clamp_en           enables the upper clamp for this beat
//   out_valid/ready    output handshake
//   out_data, out_last activated lanes and the delayed end-of-frame marker
//   frame_neg          negative-lane count of the last completed frame
//   frame_done         one-cycle pulse when frame_neg is updated
//
// Optional feature macro: RELU_LEAKY_EN (leaky negative slope).

module relu_pipe #(
  parameter int                 DATA_W     = 32,
  parameter int                 LANES      = 4,
  parameter int                 FRAC_W     = 16,
  parameter logic [DATA_W-1:0]  CLAMP_MAX  = 32'h0006_0000,
  parameter int                 LEAK_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_last,
  input  logic                      clamp_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  output logic [15:0]               frame_neg,
  output logic                      frame_done
);

  localparam int CNT_W = $clog2(LANES + 1);

  // FRAC_W only documents the fixed-point format in which CLAMP_MAX is
  // expressed; the datapath itself does not depend on it.
  logic [31:0] frac_w_unused;
  assign frac_w_unused = 32'(FRAC_W);

  // ---------------------------------------------------------------------
  // Pipeline enable
  // ---------------------------------------------------------------------
  logic en;
  logic out_valid_q;

  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;

  // ---------------------------------------------------------------------
  // Stage 1: capture the beat and each lane's sign bit
  // ---------------------------------------------------------------------
  logic                    s1_valid_q;
  logic [LANES*DATA_W-1:0] s1_data_q;
  logic                    s1_last_q;
  logic                    s1_clamp_q;
  logic [LANES-1:0]        s1_neg_q;
  logic [LANES-1:0]        s1_neg_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_clamp_q <= 1'b0;
      s1_neg_q   <= '0;
    end else if (en) begin
      // A bubble (in_valid=0) loads a valid=0 slot. The payload that moves
      // with it is never observed downstream.
      s1_valid_q <= in_valid;
      s1_data_q  <= in_data;
      s1_last_q  <= in_last;
      s1_clamp_q <= clamp_en;
      s1_neg_q   <= s1_neg_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-lane activation, computed from the stage-1 contents
  // ---------------------------------------------------------------------
  logic [LANES*DATA_W-1:0] act_d;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] lane_x;
      logic [DATA_W-1:0] lane_y;

      assign s1_neg_d[gi] = in_data[gi*DATA_W + DATA_W - 1];
      assign lane_x       = s1_data_q[gi*DATA_W +: DATA_W];

      always_comb begin
        lane_y = lane_x;
        if (s1_neg_q[gi]) begin
`ifdef RELU_LEAKY_EN
          // The arithmetic shift keeps the sign, so the result stays
          // negative (or rounds toward minus infinity down to -1).
          lane_y = DATA_W'($signed(lane_x) >>> LEAK_SHIFT);
`else
          lane_y = '0;
`endif
        end else if (s1_clamp_q && ($signed(lane_x) > $signed(CLAMP_MAX))) begin
          // Strictly greater than: a value equal to the bound passes through.
          lane_y = CLAMP_MAX;
        end
      end

      assign act_d[gi*DATA_W +: DATA_W] = lane_y;
    end
  endgenerate

`ifndef RELU_LEAKY_EN
  logic [31:0] leak_shift_unused;
  assign leak_shift_unused = 32'(LEAK_SHIFT);
`endif

  // Number of negative lanes in the stage-1 beat.
  logic [CNT_W-1:0] neg_cnt_d;

  always_comb begin
    neg_cnt_d = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_cnt_d = neg_cnt_d + CNT_W'(s1_neg_q[i]);
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: output register
  // ---------------------------------------------------------------------
  logic [LANES*DATA_W-1:0] out_data_q;
  logic                    out_last_q;
  logic [CNT_W-1:0]        out_neg_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_neg_cnt_q <= '0;
    end else if (en) begin
      out_valid_q   <= s1_valid_q;
      out_data_q    <= act_d;
      out_last_q    <= s1_last_q;
      out_neg_cnt_q <= neg_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // ---------------------------------------------------------------------
  // Frame negative counter
  // ---------------------------------------------------------------------
  // Counting happens on output transfers rather than at input. A beat
  // that is flushed by reset therefore never contributes to any frame.
  logic        out_xfer;
  logic [15:0] run_cnt_q;
  logic [15:0] frame_neg_q;
  logic        frame_done_q;
  logic [16:0] run_sum;
  logic [15:0] run_sat_d;

  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    run_sum   = {1'b0, run_cnt_q} + 17'(out_neg_cnt_q);
    run_sat_d = run_sum[16] ? 16'hFFFF : run_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q    <= '0;
      frame_neg_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (out_xfer) begin
        if (out_last_q) begin
          frame_neg_q  <= run_sat_d;
          frame_done_q <= 1'b1;
          run_cnt_q    <= '0;
        end else begin
          run_cnt_q    <= run_sat_d;
        end
      end
    end
  end

  assign frame_neg  = frame_neg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_pipe.sv
// Self-checking bench for relu_pipe (LANES=4, DATA_W=32, default parameters).
// Expected beats are pushed to a scoreboard queue when the DUT accepts them.
// A monitor pops and compares them on each output transfer. Expected frame
// counts are queued in the same way and compared on each frame_done pulse.
// Build with +define+RELU_LEAKY_EN to exercise the leaky variant.

module tb_relu_pipe;

  localparam int DW = 32;
  localparam int NL = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic           in_last;
  logic           clamp_en;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           out_last;
  logic [15:0]    frame_neg;
  logic           frame_done;

  relu_pipe #(.DATA_W(DW), .LANES(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .clamp_en   (clamp_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_neg  (frame_neg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [128:0] exp_q[$];     // {last, data}
  logic [15:0]  frame_q[$];
  int           tb_run = 0;

  // Golden per-lane activation.
  function automatic logic [127:0] model(input logic [127:0] d, input logic clamp);
    logic [127:0] r;
    logic signed [31:0] v;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      v = d[i*DW +: DW];
      if (v < 0) begin
`ifdef RELU_LEAKY_EN
        r[i*DW +: DW] = v >>> 3;
`else
        r[i*DW +: DW] = 32'h0;
`endif
      end else if (clamp && v > 32'sh0006_0000) begin
        r[i*DW +: DW] = 32'h0006_0000;
      end else begin
        r[i*DW +: DW] = v;
      end
    end
    return r;
  endfunction

  function automatic int count_neg(input logic [127:0] d);
    int c;
    logic signed [31:0] v;
    c = 0;
    for (int i = 0; i < NL; i++) begin
      v = d[i*DW +: DW];
      if (v < 0) c++;
    end
    return c;
  endfunction

  // Scoreboard monitor, plus a check that the output holds while stalled.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          n_err++;
          $display("FAIL hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected output d=%h l=%b", out_data, out_last);
        end else begin
          logic [128:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_err++;
            $display("FAIL beat: got l=%b d=%h, need l=%b d=%h",
                     out_last, out_data, e[128], e[127:0]);
          end else begin
            $display("beat ok: l=%b d=%h", out_last, out_data);
          end
        end
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        n_vec++;
        if (frame_q.size() == 0) begin
          n_err++;
          $display("FAIL frame: unexpected frame_done, frame_neg=%0d", frame_neg);
        end else begin
          logic [15:0] f;
          f = frame_q.pop_front();
          if (frame_neg !== f) begin
            n_err++;
            $display("FAIL frame: frame_neg got %0d, need %0d", frame_neg, f);
          end else begin
            $display("frame ok: frame_neg=%0d", frame_neg);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Present one beat and wait (bounded) until it is accepted.
  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [127:0] d, input logic last, input logic clamp);
    int n;
    logic ok;
    int s;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    clamp_en = clamp;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept: in_ready stuck at %b, need 1", in_ready);
    end else begin
      exp_q.push_back({last, model(d, clamp)});
      s = tb_run + count_neg(d);
      if (s > 65535) s = 65535;
      if (last) begin
        frame_q.push_back(16'(s));
        tb_run = 0;
      end else begin
        tb_run = s;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard is empty, then let frame_done settle.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || frame_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || frame_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d beats and %0d frames outstanding, need 0",
               exp_q.size(), frame_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    frame_q.delete();
    tb_run = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        frame_neg !== 16'h0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got v=%b d=%h l=%b fn=%0d fd=%b, need all 0",
               out_valid, out_data, out_last, frame_neg, frame_done);
    end else begin
      $display("reset ok");
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: in_ready got %b, need 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send({32'hFF0F_FFFE, 32'h0000_0001, 32'h0000_0006, 32'h0000_0000}, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency1: out_valid got %b, need 0", out_valid);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== {32'h0, 32'h1, 32'h6, 32'h0}) begin
      n_err++;
      $display("FAIL latency2: got v=%b d=%h, need v=1 d=%h",
               out_valid, out_data, {32'h0, 32'h1, 32'h6, 32'h0});
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_clamp();
    out_ready = 1'b1;
    send({32'h0007_0000, 32'h0006_0000, 32'h0001_0000, 32'h8000_0000}, 1'b1, 1'b1);
    send({32'h0007_0000, 32'h7FFF_FFFF, 32'h0006_0001, 32'hFFF8_0000}, 1'b1, 1'b0);
    send({32'h7FFF_FFFF, 32'h0006_0001, 32'h0005_FFFF, 32'h0000_0000}, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_stall();
    logic [127:0] held;
    out_ready = 1'b0;
    fork
      begin
        send({32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0013, 32'h0000_0014}, 1'b0, 1'b0);
        send({32'h0000_0021, 32'h0000_0022, 32'h8000_0000, 32'h0000_0024}, 1'b0, 1'b0);
        send({32'h0000_0031, 32'h0000_0032, 32'h0000_0033, 32'h0009_0000}, 1'b1, 1'b1);
      end
      begin
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          n_vec++;
          if (in_ready !== 1'b0 || out_data !== held || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall: got rdy=%b v=%b d=%h, need rdy=0 v=1 d=%h",
                     in_ready, out_valid, out_data, held);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_frame();
    int d0;
    out_ready = 1'b1;
    d0 = done_cnt;
    send({32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0001_0000}, 1'b0, 1'b0);
    send({32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004}, 1'b0, 1'b0);
    send({32'hFFFF_FFFF, 32'h8000_0001, 32'hFFF8_0000, 32'hC000_0000}, 1'b1, 1'b0);
    drain();
    n_vec++;
    if (frame_neg !== 16'd6 || done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL frame3: frame_neg=%0d pulses=%0d, need 6 and 1",
               frame_neg, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic stop;
    d0 = done_cnt;
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'($urandom_range(0, 1)));
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    n_vec++;
    if (done_cnt - d0 !== 12) begin
      n_err++;
      $display("FAIL pulses: got %0d frame_done pulses, need 12", done_cnt - d0);
    end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 16400; i++) begin
      send({4{32'h8000_0000}}, (i == 16399), 1'b0);
    end
    drain();
    n_vec++;
    if (frame_neg !== 16'hFFFF) begin
      n_err++;
      $display("FAIL saturate: frame_neg got %h, need FFFF", frame_neg);
    end
  endtask

  task automatic test_leaky();
    out_ready = 1'b1;
    send({32'h0000_0000, 32'h0000_0001, 32'h0002_0000, 32'hFFF8_0000}, 1'b1, 1'b0);
    drain();
    n_vec++;
    if (frame_neg !== 16'd1) begin
      n_err++;
      $display("FAIL leaky_count: frame_neg got %0d, need 1", frame_neg);
    end
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    send({32'hFFFF_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003}, 1'b0, 1'b0);
    send({32'hFFFF_0000, 32'h8000_0000, 32'h0000_0002, 32'h0000_0003}, 1'b0, 1'b0);
    do_reset();
    send({32'h0000_0004, 32'h0000_0005, 32'hF000_0000, 32'h0000_0007}, 1'b1, 1'b0);
    drain();
    n_vec++;
    if (frame_neg !== 16'd1) begin
      n_err++;
      $display("FAIL reset_frame: frame_neg got %0d, need 1", frame_neg);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    clamp_en  = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_clamp();
    test_stall();
    test_frame();
    test_back_to_back();
    test_leaky();
    test_reset_midframe();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/relu_pipe.md
RELU_PIPE -- requirements
Module: relu_pipe

Interface
REQ-001 Parameter DATA_W, default 32: signed two's-complement fixed-point element width.
REQ-002 Parameter LANES, default 4: elements per beat, all processed in parallel.
REQ-003 Parameter FRAC_W, default 16: fractional bits of each element; informational, used by CLAMP_MAX.
REQ-004 Parameter CLAMP_MAX, default 32'h0006_0000 (6.0): upper clamp bound, DATA_W bits, positive.
REQ-005 Parameter LEAK_SHIFT, default 3: arithmetic right-shift for negative inputs in leaky mode.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_ready  out  1  block accepts input beat this cycle.
REQ-011 in_data  in  LANES*DATA_W  packed elements; lane i = bits [i*DATA_W +: DATA_W].
REQ-012 in_last  in  1  final beat of a frame.
REQ-013 clamp_en  in  1  enables upper clamp; sampled with each accepted beat.
REQ-014 out_valid  out  1  output beat valid.
REQ-015 out_ready  in  1  downstream accepts output beat.
REQ-016 out_data  out  LANES*DATA_W  activated elements, same lane packing.
REQ-017 out_last  out  1  in_last delayed with its beat.
REQ-018 frame_neg  out  16  negative-element count of the last completed frame.
REQ-019 frame_done  out  1  one-cycle pulse when frame_neg updates.

Function
REQ-020 Per lane: MSB=1 (negative) gives 0; otherwise x, or min(x, CLAMP_MAX) when the beat's clamp_en=1.
REQ-021 Two register stages: S1 captures in_data/in_last/clamp_en and per-lane negative flags; S2 holds activated result; out_* driven from S2.
REQ-022 Latency 2 cycles from input transfer (in_valid&in_ready) to out_valid, no stall; throughput 1 beat/cycle.
REQ-023 Pipeline enable en = out_ready | ~out_valid; in_ready = en; both stages advance only when en=1.
REQ-024 out_data, out_last, out_valid SHALL hold stable while out_valid=1 and out_ready=0; no beat dropped, duplicated or reordered.
REQ-025 Bubble: in_valid=0 at an enabled cycle propagates a valid=0 slot; bubbles do not affect data order.
REQ-026 Running counter adds popcount of negative lanes on each output transfer (out_valid&out_ready), saturating at 16'hFFFF.
REQ-027 Output transfer with out_last=1: frame_neg <= running count incl. that beat's negatives; frame_done=1 next cycle only; running count restarts at 0.
REQ-028 Single-beat frames (every beat last) each produce a frame_done pulse; back-to-back pulses permitted.
REQ-029 Comparison with CLAMP_MAX is signed, full DATA_W width; x == CLAMP_MAX passes unchanged.

Reset
REQ-030 reset=1 at a clock edge: out_valid=0, out_data=0, out_last=0, frame_neg=0, frame_done=0, running count=0, S1 valid=0.
REQ-031 Reset mid-frame discards all in-flight beats and partial counts; in_ready=1 the cycle after reset deasserts.

Configuration
REQ-032 Macro RELU_LEAKY_EN defined: negative lanes output x >>> LEAK_SHIFT (sign-preserving) instead of 0; still counted as negative.
REQ-033 Macro RELU_LEAKY_EN undefined: negative lanes output 0; no shifter logic present.

Verification (LANES=4, DATA_W=32, FRAC_W=16, defaults)
REQ-034 Beat {FF0FFFFE,00000001,00000006,00000000}, clamp_en=0, out_ready=1 -> 2 cycles later out_data {0,1,6,0}.
REQ-035 clamp_en=1, lanes {00070000,00060000,00010000,80000000} -> {00060000,00060000,00010000,0}.
REQ-036 3 beats sent, out_ready=0 for 5 cycles -> in_ready=0 once full, out_data frozen; release -> 3 beats in order, none lost.
REQ-037 Frame of 3 beats with 2,0,4 negative lanes, last on beat 3 -> single frame_done pulse, frame_neg=6.
REQ-038 reset asserted after 2 of 3 frame beats -> all outputs 0; subsequent 1-beat frame with 1 negative -> frame_neg=1.
REQ-039 RELU_LEAKY_EN defined, lane FFF80000 (-8.0) -> FFFF0000 (-1.0), counted negative.
